// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared types for the memory request controller. Holds the
//               address/data widths of the 4Kx8 memory macro, the controller
//               FSM state encoding and the packed request word that is stored
//               in the request FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    // One FIFO entry: write flag, address, write data.
    localparam int REQ_W  = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] add;
        logic [DATA_W-1:0] din;
    } mem_req_t;

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/mem_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_fifo
// Description : Synchronous request FIFO with first-word fall-through read
//               data. Push is ignored when full, pop is ignored when empty;
//               a simultaneous push and pop leaves the count unchanged.
// Ports       : clk, rst (sync, active-low)
//               push/push_data  - write side
//               pop/pop_data    - read side, pop_data is the current head
//               full/empty/count- occupancy derived from the registered count
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int             PTR_W  = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;

    logic w_push;
    logic w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop  && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= push_data;
    end

    assign pop_data = r_mem[r_rptr];
    assign full     = (r_count == c_FULL);
    assign empty    = (r_count == '0);
    assign count    = r_count;

endmodule : mem_req_fifo
`default_nettype wire

// File: rtl/mem_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_ctrl
// Description : Request controller in front of the 4Kx8 memory macro.
//               Host requests are queued in a DEPTH-entry FIFO and issued one
//               at a time on cen/rd/wr/add/din. Reads wait RD_LAT cycles,
//               capture dout and return it as a one-cycle rsp_valid pulse.
// Ports       : clk, rst (sync, active-low)
//               req_valid/req_ready/req_wr/req_add/req_din - host request
//               rsp_valid/rsp_data/rsp_add                 - read response
//               cen/rd/wr/add/din/dout                     - memory pins
// Options     : MEM_REQ_CTRL_STATS_EN adds wr_cnt, rd_cnt, full_cnt (16-bit
//               saturating activity counters).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_add,
    input  logic [DATA_W-1:0] req_din,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_add,
    output logic              cen,
    output logic              rd,
    output logic              wr,
    output logic [ADDR_W-1:0] add,
    output logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] dout
`ifdef MEM_REQ_CTRL_STATS_EN
    ,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       full_cnt
`endif
);

    // WAIT lasts RD_LAT cycles; the counter runs 0 .. RD_LAT-1.
    localparam logic [2:0] c_LAT_LAST = 3'(RD_LAT - 1);

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    mem_req_t                 w_push_req;
    mem_req_t                 w_head;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_pop;
    logic [$clog2(DEPTH):0]   w_count;
    logic                     w_unused_count;

    assign w_push_req.wr  = req_wr;
    assign w_push_req.add = req_add;
    assign w_push_req.din = req_din;

    mem_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_valid),
        .push_data (w_push_req),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // Occupancy is only needed as full/empty here.
    assign w_unused_count = ^w_count;

    // Registered count feeds full, so a pop while full does not reopen
    // the request port until the following cycle.
    assign req_ready = !w_full;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_lat_cnt;
    logic              w_lat_done;
    logic              r_is_wr;

    logic              r_cen;
    logic              r_rd;
    logic              r_wr;
    logic [ADDR_W-1:0] r_add;
    logic [DATA_W-1:0] r_din;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic [ADDR_W-1:0] r_rsp_add;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_lat_done  = (r_lat_cnt == c_LAT_LAST);
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS:  w_state_nxt = r_is_wr ? IDLE : WAIT;
            WAIT:    if (w_lat_done) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Memory pins and response are registered from the next-state decode so
    // they line up exactly with the state they belong to and never glitch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_lat_cnt   <= '0;
            r_is_wr     <= 1'b0;
            r_cen       <= 1'b1;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_add       <= '0;
            r_din       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_add   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cen   <= !((w_state_nxt == ACCESS) || (w_state_nxt == WAIT));
            // Only the IDLE->ACCESS transition pops, so strobes last one cycle.
            r_rd    <= w_pop && !w_head.wr;
            r_wr    <= w_pop &&  w_head.wr;
            if (w_pop) begin
                r_add   <= w_head.add;
                r_din   <= w_head.din;
                r_is_wr <= w_head.wr;
            end
            r_lat_cnt   <= (r_state == WAIT) ? r_lat_cnt + 3'd1 : 3'd0;
            r_rsp_valid <= (r_state == WAIT) && w_lat_done;
            if ((r_state == WAIT) && w_lat_done) begin
                r_rsp_data <= dout;
                r_rsp_add  <= r_add;
            end
        end
    end

    assign cen       = r_cen;
    assign rd        = r_rd;
    assign wr        = r_wr;
    assign add       = r_add;
    assign din       = r_din;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_add   = r_rsp_add;

    // ------------------------------------------------------------------
    // Optional activity counters
    // ------------------------------------------------------------------
`ifdef MEM_REQ_CTRL_STATS_EN
    logic [15:0] r_wr_cnt;
    logic [15:0] r_rd_cnt;
    logic [15:0] r_full_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_full_cnt <= '0;
        end else begin
            if ((r_state == ACCESS) && r_is_wr && (r_wr_cnt != 16'hFFFF))
                r_wr_cnt <= r_wr_cnt + 16'd1;
            if ((r_state == ACCESS) && !r_is_wr && (r_rd_cnt != 16'hFFFF))
                r_rd_cnt <= r_rd_cnt + 16'd1;
            if (req_valid && !req_ready && (r_full_cnt != 16'hFFFF))
                r_full_cnt <= r_full_cnt + 16'd1;
        end
    end

    assign wr_cnt   = r_wr_cnt;
    assign rd_cnt   = r_rd_cnt;
    assign full_cnt = r_full_cnt;
`endif

endmodule : mem_req_ctrl
`default_nettype wire
